// File: rtl/led_feedback_arbiter_if.sv
// LED-bank arbitration bus: requester inputs (player, key echo, result
// animation) and the arbiter's LED drive and ownership status.
interface led_feedback_arbiter_if;
   logic       play_active;
   logic [7:0] play_led;
   logic       key_valid;
   logic [3:0] key_code;
   logic       res_req;
   logic       res_pass;
   logic [7:0] led_out;
   logic [1:0] grant;
   logic       busy;
   logic       res_done;

   // Handshake: play_active is a level; key_valid and res_req are
   // single-cycle pulses qualified by key_code / res_pass in that cycle.
   // There is no back-pressure; requests not granted are dropped.
   modport master (
      output play_active, play_led, key_valid, key_code, res_req, res_pass,
      input  led_out, grant, busy, res_done
   );

   modport slave (
      input  play_active, play_led, key_valid, key_code, res_req, res_pass,
      output led_out, grant, busy, res_done
   );
endinterface

// File: rtl/led_feedback_arbiter.sv
// Fixed-priority owner of the 8-LED bank: result animation > pattern player
// > key echo, with per-owner hold/blink timers and a registered LED drive.
module led_feedback_arbiter #(
   parameter int ECHO_CYC   = 5_000_000,
   parameter int BLINK_CYC  = 12_500_000,
   parameter int RES_BLINKS = 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   led_feedback_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_ECHO = 2'd2,
      S_RES  = 2'd3
   } state_t;

   localparam int EW = (ECHO_CYC   > 1) ? $clog2(ECHO_CYC)   : 1;
   localparam int BW = (BLINK_CYC  > 1) ? $clog2(BLINK_CYC)  : 1;
   localparam int PW = (RES_BLINKS > 1) ? $clog2(RES_BLINKS) : 1;

   localparam logic [EW-1:0] ECHO_LAST  = EW'(ECHO_CYC - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);
   localparam logic [PW-1:0] PHASE_LAST = PW'(RES_BLINKS - 1);

   state_t        state_q;
   logic [7:0]    led_q;
   logic          res_done_q;
   logic          pass_q;
   logic [EW-1:0] echo_q;
   logic [BW-1:0] blink_q;
   logic [PW-1:0] phase_q;

   logic       key_ok_d;
   logic [7:0] echo_led_d;
   logic [7:0] pat_a_d;
   logic [7:0] pat_b_d;

   assign key_ok_d   = bus.key_valid && !bus.key_code[3];
   assign echo_led_d = 8'b1 << bus.key_code[2:0];
   assign pat_a_d    = pass_q ? 8'hFF : 8'hAA;
   assign pat_b_d    = pass_q ? 8'h00 : 8'h55;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         led_q      <= 8'h00;
         res_done_q <= 1'b0;
         pass_q     <= 1'b0;
         echo_q     <= '0;
         blink_q    <= '0;
         phase_q    <= '0;
      end else begin
         res_done_q <= 1'b0;
         if (bus.res_req) begin
            // Restarts even when already animating.
            state_q <= S_RES;
            pass_q  <= bus.res_pass;
            phase_q <= '0;
            blink_q <= '0;
            led_q   <= bus.res_pass ? 8'hFF : 8'hAA;
         end else begin
            case (state_q)
               S_IDLE, S_ECHO: begin
                  if (bus.play_active) begin
                     state_q <= S_PLAY;
                     led_q   <= bus.play_led;
                  end else if (key_ok_d) begin
                     state_q <= S_ECHO;
                     echo_q  <= '0;
                     led_q   <= echo_led_d;
                  end else if (state_q == S_ECHO) begin
                     if (echo_q == ECHO_LAST) begin
                        state_q <= S_IDLE;
                        echo_q  <= '0;
                        led_q   <= 8'h00;
                     end else begin
                        echo_q <= echo_q + 1'b1;
                     end
                  end
               end
               S_PLAY: begin
                  if (bus.play_active) begin
                     led_q <= bus.play_led;
                  end else begin
                     state_q <= S_IDLE;
                     led_q   <= 8'h00;
                  end
               end
               S_RES: begin
                  if (blink_q == BLINK_LAST) begin
                     blink_q <= '0;
                     if (phase_q == PHASE_LAST) begin
                        res_done_q <= 1'b1;
                        phase_q    <= '0;
                        if (bus.play_active) begin
                           state_q <= S_PLAY;
                           led_q   <= bus.play_led;
                        end else begin
                           state_q <= S_IDLE;
                           led_q   <= 8'h00;
                        end
                     end else begin
                        // Next phase parity is the inverse of the current one.
                        phase_q <= phase_q + 1'b1;
                        led_q   <= phase_q[0] ? pat_a_d : pat_b_d;
                     end
                  end else begin
                     blink_q <= blink_q + 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign bus.led_out  = led_q;
   assign bus.grant    = state_q;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.res_done = res_done_q;

endmodule

// File: tb/tb_led_feedback_arbiter.sv
// Directed bench for led_feedback_arbiter with ECHO_CYC=4, BLINK_CYC=3,
// RES_BLINKS=4; expected LED sequences are queued and popped per cycle.
module tb_led_feedback_arbiter;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   logic [7:0] exp_q[$];

   led_feedback_arbiter_if bus ();

   led_feedback_arbiter #(
      .ECHO_CYC   (4),
      .BLINK_CYC  (3),
      .RES_BLINKS (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%02h exp=%02h t=%0t", tag, got, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.play_active = 1'b0;
      bus.play_led    = 8'h00;
      bus.key_valid   = 1'b0;
      bus.key_code    = 4'h0;
      bus.res_req     = 1'b0;
      bus.res_pass    = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [7:0] led, input logic [1:0] g,
                          input logic done);
      chk({tag, "_led"}, bus.led_out, led);
      chk({tag, "_grant"}, {6'd0, bus.grant}, {6'd0, g});
      chk({tag, "_busy"}, {7'd0, bus.busy}, {7'd0, (g != 2'd0)});
      chk({tag, "_done"}, {7'd0, bus.res_done}, {7'd0, done});
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      idle_inputs();
      rst_n = 1'b0;

      // Reset held with inputs toggling
      for (int i = 0; i < 5; i++) begin
         bus.play_active = 1'($urandom_range(0, 1));
         bus.play_led    = 8'($urandom_range(0, 255));
         bus.key_valid   = 1'($urandom_range(0, 1));
         bus.key_code    = 4'($urandom_range(0, 15));
         bus.res_req     = 1'($urandom_range(0, 1));
         bus.res_pass    = 1'($urandom_range(0, 1));
         step();
         chk_out("reset", 8'h00, 2'd0, 1'b0);
      end
      idle_inputs();
      rst_n = 1'b1;
      step();
      chk_out("post_reset", 8'h00, 2'd0, 1'b0);

      // Echo hold: key 5 lights bit 5 for exactly 4 cycles
      bus.key_valid = 1'b1; bus.key_code = 4'd5;
      step();
      bus.key_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_out("echo_hold", 8'h20, 2'd2, 1'b0);
         step();
      end
      chk_out("echo_timeout", 8'h00, 2'd0, 1'b0);

      // Retrigger: key 2, then key 7 two cycles later
      bus.key_valid = 1'b1; bus.key_code = 4'd2;
      step();
      bus.key_valid = 1'b0;
      chk_out("retrig_k2a", 8'h04, 2'd2, 1'b0);
      step();
      chk_out("retrig_k2b", 8'h04, 2'd2, 1'b0);
      bus.key_valid = 1'b1; bus.key_code = 4'd7;
      step();
      bus.key_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_out("retrig_k7", 8'h80, 2'd2, 1'b0);
         step();
      end
      chk_out("retrig_end", 8'h00, 2'd0, 1'b0);

      // Invalid key code
      bus.key_valid = 1'b1; bus.key_code = 4'd9;
      step();
      bus.key_valid = 1'b0;
      chk_out("key9_ignored", 8'h00, 2'd0, 1'b0);

      // Play pass-through, key ignored, drop
      bus.play_active = 1'b1; bus.play_led = 8'h3C;
      step();
      chk_out("play_enter", 8'h3C, 2'd1, 1'b0);
      bus.key_valid = 1'b1; bus.key_code = 4'd3;
      step();
      bus.key_valid = 1'b0;
      chk_out("play_key_ign", 8'h3C, 2'd1, 1'b0);
      bus.play_led = 8'h81;
      step();
      chk_out("play_follow", 8'h81, 2'd1, 1'b0);
      bus.play_active = 1'b0;
      step();
      chk_out("play_exit", 8'h00, 2'd0, 1'b0);

      // Fail result pre-empting play; returns to play afterwards
      bus.play_active = 1'b1; bus.play_led = 8'h3C;
      step();
      chk_out("fail_pre_play", 8'h3C, 2'd1, 1'b0);
      bus.res_req = 1'b1; bus.res_pass = 1'b0;
      step();
      bus.res_req = 1'b0;
      for (int p = 0; p < 4; p++)
         for (int c = 0; c < 3; c++) exp_q.push_back(p[0] ? 8'h55 : 8'hAA);
      for (int i = 0; i < 12; i++) begin
         chk_out("fail_anim", exp_q.pop_front(), 2'd3, 1'b0);
         step();
      end
      chk_out("fail_done", 8'h3C, 2'd1, 1'b1);
      step();
      chk_out("fail_done_pulse", 8'h3C, 2'd1, 1'b0);
      bus.play_active = 1'b0;
      step();
      chk_out("fail_to_idle", 8'h00, 2'd0, 1'b0);

      // Simultaneous requests, then restart in phase 2
      bus.res_req = 1'b1; bus.res_pass = 1'b1;
      bus.play_active = 1'b1; bus.play_led = 8'h0F;
      bus.key_valid = 1'b1; bus.key_code = 4'd1;
      step();
      idle_inputs();
      exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};
      for (int i = 0; i < 7; i++) begin
         chk_out("simul_pass", exp_q.pop_front(), 2'd3, 1'b0);
         if (i < 6) step();
      end
      bus.res_req = 1'b1; bus.res_pass = 1'b0;
      step();
      bus.res_req = 1'b0;
      for (int p = 0; p < 4; p++)
         for (int c = 0; c < 3; c++) exp_q.push_back(p[0] ? 8'h55 : 8'hAA);
      for (int i = 0; i < 12; i++) begin
         chk_out("restart_anim", exp_q.pop_front(), 2'd3, 1'b0);
         step();
      end
      chk_out("restart_done", 8'h00, 2'd0, 1'b1);
      step();
      chk_out("restart_after", 8'h00, 2'd0, 1'b0);

      // Asynchronous reset mid-animation: immediate, no res_done
      bus.res_req = 1'b1; bus.res_pass = 1'b1;
      step();
      bus.res_req = 1'b0;
      chk_out("rst_mid_pre", 8'hFF, 2'd3, 1'b0);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("rst_mid_async", 8'h00, 2'd0, 1'b0);
      for (int i = 0; i < 14; i++) begin
         step();
         chk({"rst_mid_nodone"}, {7'd0, bus.res_done}, 8'h00);
      end
      rst_n = 1'b1;
      step();
      chk_out("rst_mid_release", 8'h00, 2'd0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
